alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1, meaning requester N presents an ALU operation.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1, meaning requester N's operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_op/req1_op, input, 4, carrying the alu_op_t operation code.
REQ-007 The block SHALL have ports req0_a/req1_a and req0_b/req1_b, input, DATA_W, carrying the operands.
REQ-008 The block SHALL have ports req0_setflags/req1_setflags, input, 1, meaning the operation updates the flags register.
REQ-009 The block SHALL have ports rsp0_valid/rsp1_valid, output, 1, meaning a result for requester N is held.
REQ-010 The block SHALL have ports rsp0_ready/rsp1_ready, input, 1, meaning requester N consumes the result.
REQ-011 The block SHALL have port rsp_result, output, DATA_W, the held result, shared by both requesters.
REQ-012 The block SHALL have port rsp_flags, output, 4, the held alu_flags_t {n,z,c,v} of the operation.
REQ-013 The block SHALL have ports alu_op (4), alu_a (DATA_W), alu_b (DATA_W), output, driving the combinational ALU.
REQ-014 The block SHALL have ports alu_result (DATA_W) and alu_flags (4), input, returned by the ALU in the same cycle.
REQ-015 The block SHALL have port flags_q, output, 4, the architectural NZCV flags register.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-017 In IDLE with at least one reqN_valid, the block SHALL assert ready to exactly one requester (the grant), combinationally from valid and the priority pointer, and move to EXEC.
REQ-018 reqN_ready SHALL be 0 in EXEC and RESP and for the non-granted requester; a request is accepted only on valid&&ready.
REQ-019 On acceptance, the block SHALL latch op, a, b, setflags and the grant id.
REQ-020 Arbitration SHALL be round-robin: the pointer resets to requester 0; after a grant to N the pointer selects the other requester; if only one valid, it is granted regardless of the pointer.
REQ-021 In EXEC, alu_op/alu_a/alu_b SHALL equal the latched values; in all other states they SHALL be 0.
REQ-022 In EXEC, the block SHALL capture alu_result into rsp_result and alu_flags into rsp_flags, and, if latched setflags=1, load alu_flags into flags_q, then move to RESP.
REQ-023 flags_q SHALL change only at the EXEC-to-RESP transition of a setflags=1 operation.
REQ-024 In RESP, rspN_valid SHALL be 1 only for the latched id; rsp_result/rsp_flags SHALL stay stable until rspN_ready=1, after which the block returns to IDLE.
REQ-025 rspN_ready asserted while the corresponding rspN_valid=0 SHALL be ignored.
REQ-026 Latency: accepted in cycle T, rspN_valid asserts in cycle T+2; minimum issue interval is 3 cycles.
REQ-027 Op codes 5-15 SHALL be forwarded to the ALU unchanged; the block performs no decode.
REQ-028 Requester inputs changing while not granted SHALL have no effect.

Reset
REQ-029 On rst_n low, the block SHALL immediately enter IDLE, pointer=0, and clear all latched registers, rsp_result, rsp_flags and flags_q to 0.
REQ-030 During and immediately after reset, all reqN_ready, rspN_valid and alu_* outputs SHALL be 0.
REQ-031 Reset asserted in EXEC or RESP SHALL drop the in-flight operation without emitting a response.

Verification
REQ-032 Single op: req0 ADD a=5 b=3 setflags=1 -> ready0 at T; alu_op=0000, a=5, b=3 at T+1; rsp0_valid at T+2, result=8, flags_q=0000.
REQ-033 Contention: both valid continuously after reset -> grants alternate 0,1,0,1, each response before the next grant.
REQ-034 Flags: req1 SUB a=3 b=3 setflags=1 -> result=0, flags_q=0110 (Z,C); then SUB 0-1 setflags=0 -> result=FFFFFFFF, rsp_flags N=1, flags_q unchanged.
REQ-035 Backpressure: rsp0_ready held 0 for 5 cycles -> rsp0_valid and rsp_result stable, ready0/ready1 stay 0, no new grant until consumption.
REQ-036 Reset mid-op: rst_n low during EXEC -> all outputs 0 that cycle, no rsp_valid after release, next grant goes to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
// One operation is in flight at a time: IDLE grants, EXEC drives the ALU, RESP holds the result.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_setflags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_setflags,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              ptr;
  logic              grant;
  logic              accept;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              setflags_q;
  logic              id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_next = state;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;

    // The pointer only breaks ties; a lone requester always wins.
    if (req0_valid && req1_valid) begin
      grant = ptr;
    end else if (req1_valid) begin
      grant = 1'b1;
    end

    case (state)
      IDLE: begin
        // Gated by rst_n so nothing is offered while reset is held.
        req0_ready = rst_n && req0_valid && !grant;
        req1_ready = rst_n && req1_valid && grant;
        if (req0_ready || req1_ready) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        alu_op     = op_q;
        alu_a      = a_q;
        alu_b      = b_q;
        state_next = RESP;
      end
      RESP: begin
        rsp0_valid = !id_q;
        rsp1_valid = id_q;
        if ((id_q && rsp1_ready) || (!id_q && rsp0_ready)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      setflags_q <= 1'b0;
      id_q       <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        ptr        <= ~grant;
        id_q       <= grant;
        op_q       <= grant ? req1_op : req0_op;
        a_q        <= grant ? req1_a : req0_a;
        b_q        <= grant ? req1_b : req0_b;
        setflags_q <= grant ? req1_setflags : req0_setflags;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        if (setflags_q) begin
          flags_q <= alu_flags;
        end
      end
    end
  end

endmodule
